// File: rtl/code_group_aligner.sv
// code_group_aligner
//
// Receive-side word aligner for the 1000BASE-X PCS. It sits between the PMA
// deserializer and the synchronization block. The block hunts for the comma
// pattern in a 20-bit sliding window, locks to the comma's bit offset and
// re-slices the incoming stream into true code-group boundaries.
//
// Ports:
//   clk            receive clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   rx_raw         unaligned 10-bit word, bit 9 = first received bit
//   rx_raw_valid   rx_raw carries a new word this cycle
//   rx_code_group  aligned code-group, bit 9 = 'a', bit 0 = 'j'
//   PUDI           one-cycle strobe, rx_code_group updated
//   comma_det      comma found at the locked offset in the word just emitted
//   aligned        high while in LOCKED
//   align_offset   current slice offset, 0..9
//   realign_count  number of LOCKED->HUNT transitions (saturating)
//
// Configuration:
//   ALIGN_STATS_EN  when defined, realign_count counts realignment events;
//                   when undefined, the counter is absent and the port is 0.

module code_group_aligner #(
  parameter int LOCK_COMMAS = 3,
  parameter int MISS_LIMIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  rx_raw,
  input  logic        rx_raw_valid,
  output logic [9:0]  rx_code_group,
  output logic        PUDI,
  output logic        comma_det,
  output logic        aligned,
  output logic [3:0]  align_offset,
  output logic [15:0] realign_count
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  state_t      state;
  logic [9:0]  prev;
  logic [3:0]  lock_cnt;
  logic [3:0]  miss_cnt;

  logic [19:0] win;
  logic [9:0]  cand [10];
  logic [9:0]  comma_hit;
  logic        any_hit;
  logic [3:0]  first_hit;
  logic [9:0]  sel_cg;
  logic        hit_at_off;
  logic        realign_evt;

  // Build the 20-bit window and test every one of the ten slice offsets for
  // a comma. Offset k starts k bits into the previous word.
  always_comb begin
    win       = {prev, rx_raw};
    comma_hit = '0;
    for (int k = 0; k < 10; k++) begin
      cand[k]      = win[19-k -: 10];
      comma_hit[k] = (cand[k][9:3] == 7'b0011111) || (cand[k][9:3] == 7'b1100000);
    end
  end

  // Lowest offset wins when several commas hit; scanning downward lets the
  // last assignment be the smallest k.
  always_comb begin
    first_hit = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (comma_hit[k]) first_hit = 4'(k);
    end
  end

  // Explicit mux on the current offset keeps out-of-range offsets harmless.
  always_comb begin
    sel_cg     = '0;
    hit_at_off = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (align_offset == 4'(k)) begin
        sel_cg     = cand[k];
        hit_at_off = comma_hit[k];
      end
    end
  end

  assign any_hit = |comma_hit;

  // A foreign comma while locked that would bring miss_cnt to the limit.
  assign realign_evt = rx_raw_valid && (state == LOCKED) && !hit_at_off &&
                       any_hit && ((miss_cnt + 4'd1) >= MISS_N);

  // Datapath: one registered code-group per valid word, sliced with the
  // offset in effect before this cycle's FSM update.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev          <= '0;
      rx_code_group <= '0;
      PUDI          <= 1'b0;
      comma_det     <= 1'b0;
    end else if (rx_raw_valid) begin
      prev          <= rx_raw;
      rx_code_group <= sel_cg;
      PUDI          <= 1'b1;
      comma_det     <= hit_at_off;
    end else begin
      PUDI          <= 1'b0;
      comma_det     <= 1'b0;
    end
  end

  // Alignment FSM, advanced only on valid words. The offset is kept when
  // falling back to HUNT; the next comma re-latches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      align_offset <= '0;
      lock_cnt     <= '0;
      miss_cnt     <= '0;
      aligned      <= 1'b0;
    end else if (rx_raw_valid) begin
      unique case (state)
        HUNT: begin
          if (any_hit) begin
            align_offset <= first_hit;
            lock_cnt     <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state    <= LOCKED;
              aligned  <= 1'b1;
              miss_cnt <= '0;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (hit_at_off) begin
            lock_cnt <= lock_cnt + 4'd1;
            if ((lock_cnt + 4'd1) >= LOCK_N) begin
              state    <= LOCKED;
              aligned  <= 1'b1;
              miss_cnt <= '0;
            end
          end else if (any_hit) begin
            align_offset <= first_hit;
            lock_cnt     <= 4'd1;
          end
        end
        LOCKED: begin
          if (hit_at_off) begin
            miss_cnt <= '0;
          end else if (realign_evt) begin
            state    <= HUNT;
            aligned  <= 1'b0;
            miss_cnt <= '0;
          end else if (any_hit) begin
            miss_cnt <= miss_cnt + 4'd1;
          end
        end
        default: begin
          state   <= HUNT;
          aligned <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALIGN_STATS_EN
  // Saturating realignment counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      realign_count <= '0;
    end else if (realign_evt && (realign_count != 16'hFFFF)) begin
      realign_count <= realign_count + 16'd1;
    end
  end
`else
  assign realign_count = '0;
`endif

endmodule

// File: tb/tb_code_group_aligner.sv
module tb_code_group_aligner;

  localparam int LOCK_COMMAS = 3;
  localparam int MISS_LIMIT  = 2;
  localparam logic [9:0] K28_5 = 10'h0FA;
  localparam logic [9:0] D16_2 = 10'h245;

  logic        clk;
  logic        rst;
  logic [9:0]  rx_raw;
  logic        rx_raw_valid;
  logic [9:0]  rx_code_group;
  logic        PUDI;
  logic        comma_det;
  logic        aligned;
  logic [3:0]  align_offset;
  logic [15:0] realign_count;

  code_group_aligner #(
    .LOCK_COMMAS(LOCK_COMMAS),
    .MISS_LIMIT (MISS_LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_raw       (rx_raw),
    .rx_raw_valid (rx_raw_valid),
    .rx_code_group(rx_code_group),
    .PUDI         (PUDI),
    .comma_det    (comma_det),
    .aligned      (aligned),
    .align_offset (align_offset),
    .realign_count(realign_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0]  cg;
    logic        cdet;
    logic        aligned;
    logic [3:0]  off;
    logic [15:0] rcount;
  } exp_t;

  exp_t exp_q[$];
  bit   bitq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference model: tracks the serial bit history and the aligner's rules
  // in plain integers (locked / candidate-held flags, counters).
  logic [9:0] m_prev;
  bit         m_locked;
  bit         m_have;
  int         m_off;
  int         m_lock;
  int         m_miss;
  int         m_realigns;

  function automatic void model_reset();
    m_prev     = '0;
    m_locked   = 0;
    m_have     = 0;
    m_off      = 0;
    m_lock     = 0;
    m_miss     = 0;
    m_realigns = 0;
  endfunction

  function automatic exp_t model_step(input logic [9:0] raw);
    logic [19:0] w;
    logic [9:0]  c;
    int          hits[$];
    bit          at_off;
    exp_t        e;
    w = {m_prev, raw};
    for (int k = 0; k < 10; k++) begin
      c = 10'((w >> (10 - k)) & 20'h003FF);
      if (c[9:3] == 7'h1F || c[9:3] == 7'h60) hits.push_back(k);
    end
    at_off = 0;
    foreach (hits[i]) if (hits[i] == m_off) at_off = 1;
    e.cg   = 10'((w >> (10 - m_off)) & 20'h003FF);
    e.cdet = at_off;
    if (m_locked) begin
      if (at_off) begin
        m_miss = 0;
      end else if (hits.size() > 0) begin
        m_miss++;
        if (m_miss == MISS_LIMIT) begin
          m_locked = 0;
          m_have   = 0;
          m_miss   = 0;
          if (m_realigns < 65535) m_realigns++;
        end
      end
    end else if (hits.size() > 0) begin
      if (m_have && at_off) begin
        m_lock++;
      end else begin
        m_off  = hits[0];
        m_lock = 1;
        m_have = 1;
      end
      if (m_lock >= LOCK_COMMAS) begin
        m_locked = 1;
        m_miss   = 0;
      end
    end
    e.aligned = m_locked;
    e.off     = 4'(m_off);
`ifdef ALIGN_STATS_EN
    e.rcount  = 16'(m_realigns);
`else
    e.rcount  = 16'd0;
`endif
    m_prev = raw;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) bitq.push_back(w[i]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic push_idle(input int pairs);
    for (int i = 0; i < pairs; i++) begin
      push_word(K28_5);
      push_word(D16_2);
    end
  endtask

  // Drives one cycle at the falling edge; a valid word is pulled from the
  // bit queue and its expected response is queued for the monitor.
  task automatic applyStimulus(input bit valid);
    logic [9:0] raw;
    @(negedge clk);
    rst = 1'b0;
    if (valid && bitq.size() >= 10) begin
      for (int i = 9; i >= 0; i--) raw[i] = bitq.pop_front();
      rx_raw       = raw;
      rx_raw_valid = 1'b1;
      exp_q.push_back(model_step(raw));
    end else begin
      rx_raw       = 10'($urandom);
      rx_raw_valid = 1'b0;
    end
  endtask

  task automatic run_stream(input bit gapped);
    bit v;
    v = 1'b1;
    while (bitq.size() >= 10) begin
      applyStimulus(v);
      if (gapped) v = ~v;
    end
    applyStimulus(1'b0);
    applyStimulus(1'b0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst          = 1'b1;
      rx_raw       = 10'($urandom);
      rx_raw_valid = 1'($urandom_range(0, 1));
    end
    model_reset();
    bitq.delete();
    @(posedge clk);
    #1;
    checkOutput("reset rx_code_group", 16'(rx_code_group), 16'd0);
    checkOutput("reset PUDI", 16'(PUDI), 16'd0);
    checkOutput("reset comma_det", 16'(comma_det), 16'd0);
    checkOutput("reset aligned", 16'(aligned), 16'd0);
    checkOutput("reset align_offset", 16'(align_offset), 16'd0);
    checkOutput("reset realign_count", realign_count, 16'd0);
  endtask

  // Monitor: pops one expectation per PUDI strobe, flags missing or extra
  // strobes and comma_det activity on idle cycles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (PUDI === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected PUDI", 16'(PUDI), 16'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rx_code_group", 16'(rx_code_group), 16'(e.cg));
          checkOutput("comma_det", 16'(comma_det), 16'(e.cdet));
          checkOutput("aligned", 16'(aligned), 16'(e.aligned));
          checkOutput("align_offset", 16'(align_offset), 16'(e.off));
          checkOutput("realign_count", realign_count, e.rcount);
        end
      end else begin
        if (exp_q.size() > 0) begin
          checkOutput("missing PUDI", 16'(PUDI), 16'd1);
          void'(exp_q.pop_front());
        end
        checkOutput("idle comma_det", 16'(comma_det), 16'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [15:0] exp_rc;
    rst          = 1'b1;
    rx_raw       = '0;
    rx_raw_valid = 1'b0;
`ifdef ALIGN_STATS_EN
    exp_rc = 16'd1;
`else
    exp_rc = 16'd0;
`endif

    $display("[TB] reset");
    do_reset(2);

    $display("[TB] aligned idle stream");
    push_idle(8);
    run_stream(1'b0);
    checkOutput("idle aligned", 16'(aligned), 16'd1);
    checkOutput("idle offset", 16'(align_offset), 16'd0);

    $display("[TB] shifted stream by 3 bits");
    do_reset(1);
    push_rand_bits(3);
    push_idle(8);
    run_stream(1'b0);
    checkOutput("shift aligned", 16'(aligned), 16'd1);
    checkOutput("shift offset", 16'(align_offset), 16'd3);

    $display("[TB] one-bit slip while locked");
    push_rand_bits(1);
    push_idle(8);
    run_stream(1'b0);
    checkOutput("slip aligned", 16'(aligned), 16'd1);
    checkOutput("slip offset", 16'(align_offset), 16'd4);
    checkOutput("slip realign_count", realign_count, exp_rc);

    $display("[TB] gapped valid");
    push_idle(8);
    run_stream(1'b1);
    checkOutput("gapped aligned", 16'(aligned), 16'd1);
    checkOutput("gapped offset", 16'(align_offset), 16'd4);
    checkOutput("gapped realign_count", realign_count, exp_rc);

    $display("[TB] false comma during check");
    do_reset(1);
    bitq.push_back(1'b0);
    bitq.push_back(1'b0);
    push_word(K28_5);
    bitq.push_back(1'b0);
    bitq.push_back(1'b1);
    bitq.push_back(1'b0);
    push_idle(6);
    run_stream(1'b0);
    checkOutput("false comma offset", 16'(align_offset), 16'd5);
    checkOutput("false comma aligned", 16'(aligned), 16'd1);

    $display("[TB] randomized stream");
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        push_idle(1);
      end else if (r < 6) begin
        push_word(10'($urandom));
      end else if (r < 7) begin
        push_rand_bits($urandom_range(1, 9));
      end else begin
        push_word(K28_5);
        push_word(10'($urandom));
      end
    end
    while (bitq.size() >= 10) applyStimulus($urandom_range(0, 3) != 0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("scoreboard drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
